// File: rtl/video_timing_pkg.sv
// Shared raster timing definitions: standard mode constants and total/width helpers.
// Latency: none (package only).
// Backpressure: none (package only).
package video_timing_pkg;

    // Deepest supported sync/blank alignment delay, in enabled cycles
    localparam int MAX_PIPE_DELAY = 15;

    // One complete raster mode: horizontal and vertical geometry plus sync polarity
    typedef struct packed {
        logic [15:0] h_visible;
        logic [15:0] h_front;
        logic [15:0] h_sync;
        logic [15:0] h_back;
        logic [15:0] v_visible;
        logic [15:0] v_front;
        logic [15:0] v_sync;
        logic [15:0] v_back;
        logic        h_sync_pol;
        logic        v_sync_pol;
    } mode_t;

    // Payload carried through the alignment delay line, already at output polarity
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_vec_t;

    localparam mode_t MODE_640X480_60 = '{
        h_visible: 16'd640,  h_front: 16'd16,  h_sync: 16'd96,  h_back: 16'd48,
        v_visible: 16'd480,  v_front: 16'd10,  v_sync: 16'd2,   v_back: 16'd33,
        h_sync_pol: 1'b0,    v_sync_pol: 1'b0
    };

    localparam mode_t MODE_800X600_60 = '{
        h_visible: 16'd800,  h_front: 16'd40,  h_sync: 16'd128, h_back: 16'd88,
        v_visible: 16'd600,  v_front: 16'd1,   v_sync: 16'd4,   v_back: 16'd23,
        h_sync_pol: 1'b1,    v_sync_pol: 1'b1
    };

    localparam mode_t MODE_1280X720_60 = '{
        h_visible: 16'd1280, h_front: 16'd110, h_sync: 16'd40,  h_back: 16'd220,
        v_visible: 16'd720,  v_front: 16'd5,   v_sync: 16'd5,   v_back: 16'd20,
        h_sync_pol: 1'b1,    v_sync_pol: 1'b1
    };

    // Period of one line (or one frame, in lines) from its four segments
    function automatic int calc_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    // Smallest counter width whose range strictly exceeds the given total
    function automatic int min_xy_bits(input int total);
        int bits;
        bits = 0;
        while ((longint'(1) << bits) <= longint'(total)) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/video_sync_delay.sv
// Enable-gated shift register aligning sync/blank with a downstream pixel pipeline.
// Latency: DEPTH enabled cycles from din_i to dout_o.
// Backpressure: none; stages hold while ena_i is low.
module video_sync_delay #(
    parameter int                 WIDTH   = 3,
    parameter int                 DEPTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ena_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Every stage loads the idle value on reset; otherwise shift one step per enabled cycle
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else if (ena_i) begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: beam coordinates, strobes, frame counter and delayed sync/blank.
// Latency: beam/strobes immediate; vga_* lag the beam by 1+PIPE_DELAY enabled cycles.
// Backpressure: none; clk_pixel_ena low freezes all state.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int XY_BITS    = 11,
    parameter int PIPE_DELAY = 0,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk_pixel,
    input  logic                  rst_n,
    input  logic                  clk_pixel_ena,
    output logic [XY_BITS-1:0]    beam_x,
    output logic [XY_BITS-1:0]    beam_y,
    output logic                  beam_visible,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  vga_blank,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [FRAME_BITS-1:0] frame_count
);

    localparam int H_TOTAL = calc_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = calc_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (min_xy_bits(H_TOTAL) > XY_BITS) begin : g_bad_h_total
        $error("video_timing_gen: H_TOTAL does not fit in XY_BITS");
    end
    if (min_xy_bits(V_TOTAL) > XY_BITS) begin : g_bad_v_total
        $error("video_timing_gen: V_TOTAL does not fit in XY_BITS");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_pipe_delay
        $error("video_timing_gen: PIPE_DELAY outside 0..15");
    end

    localparam logic [XY_BITS-1:0] H_LAST       = XY_BITS'(H_TOTAL - 1);
    localparam logic [XY_BITS-1:0] V_LAST       = XY_BITS'(V_TOTAL - 1);
    localparam logic [XY_BITS-1:0] H_VIS_END    = XY_BITS'(H_VISIBLE);
    localparam logic [XY_BITS-1:0] V_VIS_END    = XY_BITS'(V_VISIBLE);
    localparam logic [XY_BITS-1:0] H_SYNC_START = XY_BITS'(H_VISIBLE + H_FRONT);
    localparam logic [XY_BITS-1:0] H_SYNC_END   = XY_BITS'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [XY_BITS-1:0] V_SYNC_START = XY_BITS'(V_VISIBLE + V_FRONT);
    localparam logic [XY_BITS-1:0] V_SYNC_END   = XY_BITS'(V_VISIBLE + V_FRONT + V_SYNC);

    // Delay-line idle word: blanked, both syncs at their inactive level
    localparam sync_vec_t SYNC_IDLE = '{hsync: !H_SYNC_POL, vsync: !V_SYNC_POL, blank: 1'b1};

    logic [XY_BITS-1:0]    beam_x_q, beam_x_d;
    logic [XY_BITS-1:0]    beam_y_q, beam_y_d;
    logic [FRAME_BITS-1:0] frame_count_q, frame_count_d;
    logic                  h_visible, v_visible;
    logic                  h_active, v_active;
    sync_vec_t             sync_vec_d;
    sync_vec_t             sync_vec_q;

    // Raster advance: x wraps at end of line, y at end of frame, frame wrap bumps the counter
    always_comb begin
        beam_x_d      = beam_x_q;
        beam_y_d      = beam_y_q;
        frame_count_d = frame_count_q;
        if (clk_pixel_ena) begin
            if (beam_x_q == H_LAST) begin
                beam_x_d = '0;
                if (beam_y_q == V_LAST) begin
                    beam_y_d      = '0;
                    frame_count_d = frame_count_q + 1'b1;
                end else begin
                    beam_y_d = beam_y_q + 1'b1;
                end
            end else begin
                beam_x_d = beam_x_q + 1'b1;
            end
        end
    end

    // Counter registers; reset wins over the pixel enable
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            beam_x_q      <= '0;
            beam_y_q      <= '0;
            frame_count_q <= '0;
        end else begin
            beam_x_q      <= beam_x_d;
            beam_y_q      <= beam_y_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Undelayed window decode; vsync depends on y only so it changes on line boundaries
    always_comb begin
        h_visible        = (beam_x_q < H_VIS_END);
        v_visible        = (beam_y_q < V_VIS_END);
        h_active         = (beam_x_q >= H_SYNC_START) && (beam_x_q < H_SYNC_END);
        v_active         = (beam_y_q >= V_SYNC_START) && (beam_y_q < V_SYNC_END);
        sync_vec_d.hsync = h_active ? H_SYNC_POL : !H_SYNC_POL;
        sync_vec_d.vsync = v_active ? V_SYNC_POL : !V_SYNC_POL;
        sync_vec_d.blank = !(h_visible && v_visible);
    end

    video_sync_delay #(
        .WIDTH   ($bits(sync_vec_t)),
        .DEPTH   (1 + PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk_i   (clk_pixel),
        .rst_n_i (rst_n),
        .ena_i   (clk_pixel_ena),
        .din_i   (sync_vec_d),
        .dout_o  (sync_vec_q)
    );

    assign beam_x       = beam_x_q;
    assign beam_y       = beam_y_q;
    assign frame_count  = frame_count_q;
    assign beam_visible = h_visible && v_visible;
    assign line_start   = clk_pixel_ena && (beam_x_q == '0);
    assign frame_start  = line_start && (beam_y_q == '0);
    assign vga_hsync    = sync_vec_q.hsync;
    assign vga_vsync    = sync_vec_q.vsync;
    assign vga_blank    = sync_vec_q.blank;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen across default, delayed, small and 720p instances.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default 640x480 instance
    logic        rst_def_n, ena_def;
    logic [10:0] d_x, d_y;
    logic        d_vis, d_hs, d_vs, d_bl, d_ls, d_fs;
    logic [15:0] d_fc;

    // Default geometry with PIPE_DELAY=5
    logic        rst_pd_n, ena_pd;
    logic [10:0] p_x, p_y;
    logic        p_vis, p_hs, p_vs, p_bl, p_ls, p_fs;
    logic [15:0] p_fc;

    // Tiny geometry: H 8/2/3/2 (15), V 4/1/2/1 (8), PIPE_DELAY=2, FRAME_BITS=2
    logic        rst_sm_n, ena_sm;
    logic [3:0]  s_x, s_y;
    logic        s_vis, s_hs, s_vs, s_bl, s_ls, s_fs;
    logic [1:0]  s_fc;

    // 1280x720 with active-high syncs
    logic        rst_hd_n, ena_hd;
    logic [10:0] h_x, h_y;
    logic        h_vis, h_hs, h_vs, h_bl, h_ls, h_fs;
    logic [15:0] h_fc;

    video_timing_gen u_def (
        .clk_pixel(clk), .rst_n(rst_def_n), .clk_pixel_ena(ena_def),
        .beam_x(d_x), .beam_y(d_y), .beam_visible(d_vis),
        .vga_hsync(d_hs), .vga_vsync(d_vs), .vga_blank(d_bl),
        .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    video_timing_gen #(.PIPE_DELAY(5)) u_pd5 (
        .clk_pixel(clk), .rst_n(rst_pd_n), .clk_pixel_ena(ena_pd),
        .beam_x(p_x), .beam_y(p_y), .beam_visible(p_vis),
        .vga_hsync(p_hs), .vga_vsync(p_vs), .vga_blank(p_bl),
        .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc)
    );

    video_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .XY_BITS(4), .PIPE_DELAY(2), .FRAME_BITS(2)
    ) u_sm (
        .clk_pixel(clk), .rst_n(rst_sm_n), .clk_pixel_ena(ena_sm),
        .beam_x(s_x), .beam_y(s_y), .beam_visible(s_vis),
        .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_blank(s_bl),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    video_timing_gen #(
        .H_VISIBLE(1280), .H_FRONT(110), .H_SYNC(40), .H_BACK(220),
        .V_VISIBLE(720), .V_FRONT(5), .V_SYNC(5), .V_BACK(20),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .XY_BITS(11)
    ) u_hd (
        .clk_pixel(clk), .rst_n(rst_hd_n), .clk_pixel_ena(ena_hd),
        .beam_x(h_x), .beam_y(h_y), .beam_visible(h_vis),
        .vga_hsync(h_hs), .vga_vsync(h_vs), .vga_blank(h_bl),
        .line_start(h_ls), .frame_start(h_fs), .frame_count(h_fc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {hsync, vsync, blank} for the tiny geometry, active-low syncs
    function automatic logic [2:0] sm_dec(input int x, input int y);
        logic hs, vs, bl;
        hs = !(x >= 10 && x < 13);
        vs = !(y >= 5 && y < 7);
        bl = !(x < 8 && y < 4);
        return {hs, vs, bl};
    endfunction

    task automatic test_reset();
        rst_def_n = 1'b0;
        ena_def   = 1'b1;
        step();
        step();
        total++; if (d_x !== 11'd0) begin bad++; $display("FAIL reset_beam_x got=%0d exp=0", d_x); end
        total++; if (d_y !== 11'd0) begin bad++; $display("FAIL reset_beam_y got=%0d exp=0", d_y); end
        total++; if (d_fc !== 16'd0) begin bad++; $display("FAIL reset_frame_count got=%0d exp=0", d_fc); end
        total++; if (d_bl !== 1'b1) begin bad++; $display("FAIL reset_blank got=%b exp=1", d_bl); end
        total++; if (d_hs !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", d_hs); end
        total++; if (d_vs !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", d_vs); end
        total++; if (d_ls !== 1'b1) begin bad++; $display("FAIL reset_line_start got=%b exp=1", d_ls); end
        total++; if (d_fs !== 1'b1) begin bad++; $display("FAIL reset_frame_start got=%b exp=1", d_fs); end
        total++; if (d_vis !== 1'b1) begin bad++; $display("FAIL reset_visible got=%b exp=1", d_vis); end
        ena_def = 1'b0;
        #1;
        total++; if (d_ls !== 1'b0) begin bad++; $display("FAIL reset_line_start_noena got=%b exp=0", d_ls); end
        total++; if (d_fs !== 1'b0) begin bad++; $display("FAIL reset_frame_start_noena got=%b exp=0", d_fs); end
    endtask

    task automatic test_hsync_line();
        int  px, py, hs_low;
        logic exp_hs, exp_bl, exp_vis;
        hs_low    = 0;
        ena_def   = 1'b1;
        rst_def_n = 1'b1;
        for (int k = 1; k <= 805; k++) begin
            step();
            px      = (k - 1) % 800;
            py      = (k - 1) / 800;
            exp_hs  = !(px >= 656 && px < 752);
            exp_bl  = !(px < 640 && py < 480);
            exp_vis = ((k % 800) < 640);
            total++; if (d_x !== 11'(k % 800)) begin bad++; $display("FAIL line_beam_x k=%0d got=%0d exp=%0d", k, d_x, k % 800); end
            total++; if (d_hs !== exp_hs) begin bad++; $display("FAIL line_hsync k=%0d got=%b exp=%b", k, d_hs, exp_hs); end
            total++; if (d_bl !== exp_bl) begin bad++; $display("FAIL line_blank k=%0d got=%b exp=%b", k, d_bl, exp_bl); end
            total++; if (d_vs !== 1'b1) begin bad++; $display("FAIL line_vsync k=%0d got=%b exp=1", k, d_vs); end
            total++; if (d_vis !== exp_vis) begin bad++; $display("FAIL line_visible k=%0d got=%b exp=%b", k, d_vis, exp_vis); end
            if (k <= 800 && d_hs == 1'b0) hs_low++;
            if (k == 800) begin
                total++; if (d_y !== 11'd1) begin bad++; $display("FAIL line_wrap_y got=%0d exp=1", d_y); end
                total++; if (d_ls !== 1'b1) begin bad++; $display("FAIL line_start_wrap got=%b exp=1", d_ls); end
                total++; if (d_fs !== 1'b0) begin bad++; $display("FAIL frame_start_line1 got=%b exp=0", d_fs); end
            end
        end
        total++; if (hs_low != 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", hs_low); end
    endtask

    task automatic test_pipe_delay();
        logic exp_bl, prev_bl;
        int   nfall;
        int   fall_at [2];
        nfall    = 0;
        fall_at  = '{-1, -1};
        rst_pd_n = 1'b0;
        ena_pd   = 1'b1;
        step();
        step();
        total++; if (p_bl !== 1'b1) begin bad++; $display("FAIL pd_reset_blank got=%b exp=1", p_bl); end
        total++; if (p_hs !== 1'b1) begin bad++; $display("FAIL pd_reset_hsync got=%b exp=1", p_hs); end
        prev_bl  = p_bl;
        rst_pd_n = 1'b1;
        for (int k = 1; k <= 810; k++) begin
            step();
            exp_bl = (k < 6) ? 1'b1 : !(((k - 6) % 800) < 640);
            total++; if (p_bl !== exp_bl) begin bad++; $display("FAIL pd_blank k=%0d got=%b exp=%b", k, p_bl, exp_bl); end
            if (prev_bl == 1'b1 && p_bl == 1'b0) begin
                if (nfall < 2) fall_at[nfall] = k;
                nfall++;
            end
            prev_bl = p_bl;
        end
        total++; if (fall_at[0] != 6) begin bad++; $display("FAIL pd_first_unblank got=%0d exp=6", fall_at[0]); end
        total++; if (fall_at[1] != 806) begin bad++; $display("FAIL pd_line1_unblank got=%0d exp=806", fall_at[1]); end
    endtask

    task automatic test_ena_toggle();
        logic [2:0] hist [3];
        int  mx, my, last_fs, nfs;
        logic exp_ls, exp_fs;
        hist     = '{3'b111, 3'b111, 3'b111};
        mx       = 0;
        my       = 0;
        last_fs  = -1;
        nfs      = 0;
        rst_sm_n = 1'b0;
        ena_sm   = 1'b0;
        step();
        step();
        rst_sm_n = 1'b1;
        for (int c = 0; c < 1440; c++) begin
            ena_sm = (c % 4 == 0);
            #1;
            exp_ls = ena_sm && (mx == 0);
            exp_fs = exp_ls && (my == 0);
            total++; if (s_x !== 4'(mx) || s_y !== 4'(my)) begin bad++; $display("FAIL tog_beam c=%0d got=%0d,%0d exp=%0d,%0d", c, s_x, s_y, mx, my); end
            total++; if (s_ls !== exp_ls) begin bad++; $display("FAIL tog_line_start c=%0d got=%b exp=%b", c, s_ls, exp_ls); end
            total++; if (s_fs !== exp_fs) begin bad++; $display("FAIL tog_frame_start c=%0d got=%b exp=%b", c, s_fs, exp_fs); end
            total++; if ({s_hs, s_vs, s_bl} !== hist[2]) begin bad++; $display("FAIL tog_delay c=%0d got=%b exp=%b", c, {s_hs, s_vs, s_bl}, hist[2]); end
            if (s_fs === 1'b1) begin
                if (last_fs >= 0) begin
                    total++; if (c - last_fs != 480) begin bad++; $display("FAIL tog_frame_period got=%0d exp=480", c - last_fs); end
                end
                last_fs = c;
                nfs++;
            end
            @(posedge clk);
            #1;
            if (ena_sm) begin
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = sm_dec(mx, my);
                if (mx == 14) begin
                    mx = 0;
                    my = (my == 7) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        end
        total++; if (nfs != 3) begin bad++; $display("FAIL tog_frame_starts got=%0d exp=3", nfs); end
    endtask

    task automatic test_frame_count();
        int   exp_seq [5];
        int   seq [5];
        int   at [5];
        int   nchg;
        logic [1:0] prev;
        exp_seq  = '{1, 2, 3, 0, 1};
        seq      = '{-1, -1, -1, -1, -1};
        at       = '{-1, -1, -1, -1, -1};
        nchg     = 0;
        rst_sm_n = 1'b0;
        ena_sm   = 1'b1;
        step();
        total++; if (s_fc !== 2'd0) begin bad++; $display("FAIL fc_reset got=%0d exp=0", s_fc); end
        prev     = s_fc;
        rst_sm_n = 1'b1;
        for (int k = 1; k <= 620; k++) begin
            step();
            if (s_fc !== prev) begin
                if (nchg < 5) begin
                    seq[nchg] = int'(s_fc);
                    at[nchg]  = k;
                end
                nchg++;
                total++; if (s_x !== 4'd0 || s_y !== 4'd0) begin bad++; $display("FAIL fc_step_pos k=%0d got=%0d,%0d exp=0,0", k, s_x, s_y); end
                prev = s_fc;
            end
        end
        total++; if (nchg != 5) begin bad++; $display("FAIL fc_steps got=%0d exp=5", nchg); end
        for (int i = 0; i < 5; i++) begin
            total++; if (seq[i] != exp_seq[i]) begin bad++; $display("FAIL fc_value i=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]); end
            total++; if (at[i] != 120 * (i + 1)) begin bad++; $display("FAIL fc_time i=%0d got=%0d exp=%0d", i, at[i], 120 * (i + 1)); end
        end
    endtask

    // Continues from test_frame_count: beam at linear index 620 -> (5,1), frame_count 1
    task automatic test_reset_midframe();
        int nfs;
        repeat (67) step();
        total++; if (s_x !== 4'd12 || s_y !== 4'd5) begin bad++; $display("FAIL mid_pos got=%0d,%0d exp=12,5", s_x, s_y); end
        total++; if (s_vs !== 1'b0) begin bad++; $display("FAIL mid_vsync_active got=%b exp=0", s_vs); end
        total++; if (s_fc !== 2'd1) begin bad++; $display("FAIL mid_fc got=%0d exp=1", s_fc); end
        rst_sm_n = 1'b0;
        step();
        total++; if (s_x !== 4'd0 || s_y !== 4'd0) begin bad++; $display("FAIL mid_reset_beam got=%0d,%0d exp=0,0", s_x, s_y); end
        total++; if (s_fc !== 2'd0) begin bad++; $display("FAIL mid_reset_fc got=%0d exp=0", s_fc); end
        total++; if ({s_hs, s_vs, s_bl} !== 3'b111) begin bad++; $display("FAIL mid_reset_sync got=%b exp=111", {s_hs, s_vs, s_bl}); end
        total++; if (s_fs !== 1'b1) begin bad++; $display("FAIL mid_reset_frame_start got=%b exp=1", s_fs); end
        nfs      = (s_fs === 1'b1) ? 1 : 0;
        rst_sm_n = 1'b1;
        for (int s = 1; s <= 250; s++) begin
            step();
            if (s_fs === 1'b1) nfs++;
            if (s == 1 || s == 2) begin
                total++; if (s_bl !== 1'b1) begin bad++; $display("FAIL mid_blank_hold s=%0d got=%b exp=1", s, s_bl); end
            end
            if (s == 3) begin
                total++; if (s_bl !== 1'b0) begin bad++; $display("FAIL mid_first_unblank got=%b exp=0", s_bl); end
            end
            if (s == 120 || s == 240) begin
                total++; if (s_fs !== 1'b1) begin bad++; $display("FAIL mid_frame_start s=%0d got=%b exp=1", s, s_fs); end
            end
        end
        total++; if (nfs != 3) begin bad++; $display("FAIL mid_frame_start_count got=%0d exp=3", nfs); end
    endtask

    task automatic test_hd_polarity();
        int   px, hs_high;
        logic exp_hs;
        hs_high  = 0;
        rst_hd_n = 1'b0;
        ena_hd   = 1'b1;
        step();
        step();
        total++; if (h_hs !== 1'b0) begin bad++; $display("FAIL hd_reset_hsync got=%b exp=0", h_hs); end
        total++; if (h_vs !== 1'b0) begin bad++; $display("FAIL hd_reset_vsync got=%b exp=0", h_vs); end
        total++; if (h_bl !== 1'b1) begin bad++; $display("FAIL hd_reset_blank got=%b exp=1", h_bl); end
        rst_hd_n = 1'b1;
        for (int k = 1; k <= 1651; k++) begin
            step();
            px     = (k - 1) % 1650;
            exp_hs = (px >= 1390 && px < 1430);
            total++; if (h_hs !== exp_hs) begin bad++; $display("FAIL hd_hsync k=%0d got=%b exp=%b", k, h_hs, exp_hs); end
            if (k <= 1650 && h_hs == 1'b1) hs_high++;
            if (k == 1649) begin
                total++; if (h_x !== 11'd1649) begin bad++; $display("FAIL hd_last_x got=%0d exp=1649", h_x); end
            end
            if (k == 1650) begin
                total++; if (h_x !== 11'd0 || h_y !== 11'd1) begin bad++; $display("FAIL hd_wrap got=%0d,%0d exp=0,1", h_x, h_y); end
                total++; if (h_ls !== 1'b1) begin bad++; $display("FAIL hd_line_start got=%b exp=1", h_ls); end
            end
        end
        total++; if (hs_high != 40) begin bad++; $display("FAIL hd_hsync_width got=%0d exp=40", hs_high); end
        total++; if (h_vs !== 1'b0) begin bad++; $display("FAIL hd_vsync_idle got=%b exp=0", h_vs); end
    endtask

    initial begin
        rst_def_n = 1'b0; ena_def = 1'b0;
        rst_pd_n  = 1'b0; ena_pd  = 1'b0;
        rst_sm_n  = 1'b0; ena_sm  = 1'b0;
        rst_hd_n  = 1'b0; ena_hd  = 1'b0;
        test_reset();
        test_hsync_line();
        test_pipe_delay();
        test_ena_toggle();
        test_frame_count();
        test_reset_midframe();
        test_hd_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
